// File: rtl/rf_alu_ctrl.sv
// rtl/rf_alu_ctrl.sv - three-cycle instruction sequencer for the register-file + ALU datapath
// Optional NZCV flag register enabled by defining RF_ALU_CTRL_FLAGS_EN.
module rf_alu_ctrl #(
  parameter int ADDR = 4,
  parameter int SIZE = 32
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  Inst_Valid,
  output logic                  Inst_Ready,
  input  logic [7+3*ADDR-1:0]   Inst,
  input  logic [SIZE-1:0]       Inst_Data,
  input  logic                  N,
  input  logic                  Z,
  input  logic                  C,
  input  logic                  V,
  output logic [ADDR-1:0]       R_Addr_A,
  output logic [ADDR-1:0]       R_Addr_B,
  output logic [ADDR-1:0]       R_Addr_C,
  output logic [ADDR-1:0]       W_Addr,
  output logic [3:0]            OP,
  output logic                  SCO,
  output logic                  CF,
  output logic                  VF,
  output logic                  Write_Reg,
  output logic                  Write_Select,
  output logic [SIZE-1:0]       Input_Data,
  output logic [3:0]            Flags,
  output logic                  Busy,
  output logic                  Done
);

  localparam int IW = 7 + 3 * ADDR;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_CMP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t            state;
  logic [IW-1:0]     ir;
  logic [SIZE-1:0]   dr;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              write_reg_q;
  logic              write_select_q;

  logic [1:0]        ir_kind;
  logic              ir_s;
  logic [3:0]        ir_op;
  logic [ADDR-1:0]   ir_rd;
  logic [ADDR-1:0]   ir_rs1;
  logic [ADDR-1:0]   ir_rs2;

  assign ir_kind = ir[IW-1 -: 2];
  assign ir_s    = ir[IW-3];
  assign ir_op   = ir[IW-4 -: 4];
  assign ir_rd   = ir[3*ADDR-1 -: ADDR];
  assign ir_rs1  = ir[2*ADDR-1 -: ADDR];
  assign ir_rs2  = ir[ADDR-1:0];

  // Sequencer: IDLE -> READ -> EXEC -> IDLE, with every control output registered
  // one state ahead so the outputs are a pure function of the current state.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state          <= ST_IDLE;
      ir             <= '0;
      dr             <= '0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      write_reg_q    <= 1'b0;
      write_select_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Inst_Valid) begin
            ir      <= Inst;
            dr      <= Inst_Data;
            state   <= ST_READ;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_READ: begin
          state          <= ST_EXEC;
          done_q         <= 1'b1;
          write_reg_q    <= (ir_kind == KIND_ALU) || (ir_kind == KIND_LOAD);
          write_select_q <= (ir_kind == KIND_LOAD);
        end
        ST_EXEC: begin
          state          <= ST_IDLE;
          ready_q        <= 1'b1;
          busy_q         <= 1'b0;
          done_q         <= 1'b0;
          write_reg_q    <= 1'b0;
          write_select_q <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          ready_q        <= 1'b1;
          busy_q         <= 1'b0;
          done_q         <= 1'b0;
          write_reg_q    <= 1'b0;
          write_select_q <= 1'b0;
        end
      endcase
    end
  end

  assign Inst_Ready   = ready_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Write_Reg    = write_reg_q;
  assign Write_Select = write_select_q;

  assign R_Addr_A   = ir_rs1;
  assign R_Addr_B   = ir_rs2;
  assign R_Addr_C   = ir_rd;
  assign W_Addr     = ir_rd;
  assign OP         = ir_op;
  assign SCO        = ir_s;
  assign Input_Data = dr;

`ifdef RF_ALU_CTRL_FLAGS_EN
  logic [3:0] flags_q;
  logic       flag_update;

  // ALU with S=1 and every CMP commit the ALU flags; LOAD and NOP never touch them.
  assign flag_update = (state == ST_EXEC) &&
                       (((ir_kind == KIND_ALU) && ir_s) || (ir_kind == KIND_CMP));

  // Flag register captures the datapath flags at the edge that ends EXEC.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      flags_q <= 4'b0000;
    end else if (flag_update) begin
      flags_q <= {N, Z, C, V};
    end
  end

  assign Flags = flags_q;
  assign CF    = flags_q[1];
  assign VF    = flags_q[0];
`else
  logic unused_alu_flags;

  assign unused_alu_flags = ^{N, Z, C, V};
  assign Flags            = 4'b0000;
  assign CF               = 1'b0;
  assign VF               = 1'b0;
`endif

endmodule
